wb_trace_buffer: RTL

- Sits directly downstream of the CPU core's write-back debug port and consumes debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum and debug_wb_rf_wdata.
- Filters qualifying register-file writes, tags each one with a sequence number, and buffers them in a FIFO.
- Drains entries through a valid/ready trace port to the difftest/trace logic in the SoC, so a slow consumer never stalls the core.
- When the FIFO is full, drops are counted so the consumer can detect gaps in the trace.

---
 rtl/wb_trace_buffer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/wb_trace_buffer.sv
// -----------------------------------------------------------------------------
// wb_trace_buffer
// Captures qualifying register-file writes from the core's write-back debug
// port, tags each one with a 16-bit sequence number and queues it in a
// first-word-fall-through FIFO. A valid/ready trace port drains the queue, so a
// slow consumer never stalls the core. Events arriving while the FIFO is full
// are dropped, but they still consume a sequence number, which leaves a visible
// gap in the trace. They are also counted in drop_cnt and flagged by the sticky
// overflow bit.
//
// Ports
//   clk, rst            core clock; asynchronous active-low reset
//   debug_wb_*          write-back debug port (pc, wen, wnum, wdata)
//   trace_en            capture enable
//   clear               synchronous flush of FIFO, sequence and drop state
//   trace_valid/ready   head-entry handshake
//   trace_seq/pc/wen/wnum/wdata  head-entry fields (all zero when empty)
//   count               current occupancy
//   overflow            sticky "at least one entry dropped"
//   drop_cnt            saturating count of dropped entries
// -----------------------------------------------------------------------------
module wb_trace_buffer #(
    parameter int DEPTH     = 16,
    parameter bit FILTER_R0 = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                debug_wb_pc,
    input  logic [3:0]                 debug_wb_rf_wen,
    input  logic [4:0]                 debug_wb_rf_wnum,
    input  logic [31:0]                debug_wb_rf_wdata,
    input  logic                       trace_en,
    input  logic                       clear,
    output logic                       trace_valid,
    input  logic                       trace_ready,
    output logic [15:0]                trace_seq,
    output logic [31:0]                trace_pc,
    output logic [3:0]                 trace_wen,
    output logic [4:0]                 trace_wnum,
    output logic [31:0]                trace_wdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [15:0]                drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = 16 + 32 + 4 + 5 + 32;
    localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

    // Entry layout: {seq, pc, wen, wnum, wdata}
    logic [EW-1:0] r_mem [DEPTH];

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [15:0]   r_seq;
    logic          r_overflow;
    logic [15:0]   r_drop_cnt;

    logic [PW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    logic          w_evt;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [EW-1:0] w_head;

    // The pointers carry one extra wrap bit, so their difference is the
    // occupancy, including the full case (count == DEPTH).
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_count == FULL_CNT);
    assign w_empty = (w_count == {PW{1'b0}});

    assign w_evt  = trace_en && (debug_wb_rf_wen != 4'h0) &&
                    !(FILTER_R0 && (debug_wb_rf_wnum == 5'd0));
    assign w_pop  = !w_empty && trace_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_push = w_evt && (!w_full || w_pop);
    assign w_drop = w_evt && w_full && !w_pop;

    // Entry storage; contents do not need a reset because the head is masked when empty.
    always_ff @(posedge clk) begin
        if (w_push && !clear) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {r_seq, debug_wb_pc, debug_wb_rf_wen,
                                        debug_wb_rf_wnum, debug_wb_rf_wdata};
        end
    end

    // Pointers, sequence counter and drop bookkeeping; clear outranks all traffic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= {PW{1'b0}};
            r_rd_ptr   <= {PW{1'b0}};
            r_seq      <= 16'h0000;
            r_overflow <= 1'b0;
            r_drop_cnt <= 16'h0000;
        end else if (clear) begin
            r_wr_ptr   <= {PW{1'b0}};
            r_rd_ptr   <= {PW{1'b0}};
            r_seq      <= 16'h0000;
            r_overflow <= 1'b0;
            r_drop_cnt <= 16'h0000;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            // Every qualifying event consumes a number, stored or dropped.
            if (w_evt) begin
                r_seq <= r_seq + 16'h0001;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 16'hFFFF) begin
                    r_drop_cnt <= r_drop_cnt + 16'h0001;
                end
            end
        end
    end

    // Head entry, forced to zero while the FIFO is empty.
    always_comb begin
        w_head = {EW{1'b0}};
        if (!w_empty) begin
            w_head = r_mem[r_rd_ptr[AW-1:0]];
        end else begin
            w_head = {EW{1'b0}};
        end
    end

    assign trace_valid = !w_empty;
    assign trace_seq   = w_head[EW-1 -: 16];
    assign trace_pc    = w_head[72:41];
    assign trace_wen   = w_head[40:37];
    assign trace_wnum  = w_head[36:32];
    assign trace_wdata = w_head[31:0];
    assign count       = w_count;
    assign overflow    = r_overflow;
    assign drop_cnt    = r_drop_cnt;

endmodule
